qpu_exu_cwbck_arbt: RTL

Arbiter for the single classical-register-file (CRF) write port in the QPU EXU. It has three requesters:
- ALU classical writeback (cwbck)
- ALU quantum-classical writeback (qcwbck; measurement/FMR results)
- long-pipe writeback (LSU load return)

It grants one requester per cycle, registers the winning write into the CRF with 1-cycle latency, and emits an OITF retire pulse for long-pipe writes. Anti-starvation counters bound the wait of any requester.

---
 rtl/qpu_exu_cwbck_arbt_if.sv | 43 ++++
 rtl/qpu_exu_cwbck_arbt.sv | 125 ++++++++++++
 2 files changed

// File: rtl/qpu_exu_cwbck_arbt_if.sv
// CRF writeback bundle: three requester channels into the arbiter and the registered CRF write out of it.
// master = requester/observer side, slave = arbiter side.
interface qpu_exu_cwbck_arbt_if #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
);
  logic               alu_wbck_i_valid;
  logic               alu_wbck_i_ready;
  logic [XLEN-1:0]    alu_wbck_i_data;
  logic [RFIDX_W-1:0] alu_wbck_i_rdidx;

  logic               qc_wbck_i_valid;
  logic               qc_wbck_i_ready;
  logic [XLEN-1:0]    qc_wbck_i_data;
  logic [RFIDX_W-1:0] qc_wbck_i_rdidx;

  logic               longp_wbck_i_valid;
  logic               longp_wbck_i_ready;
  logic [XLEN-1:0]    longp_wbck_i_data;
  logic [RFIDX_W-1:0] longp_wbck_i_rdidx;

  logic               rf_wbck_ena;
  logic [RFIDX_W-1:0] rf_wbck_rdidx;
  logic [XLEN-1:0]    rf_wbck_wdat;
  logic [1:0]         rf_wbck_src;
  logic               longp_ret_o;

  modport master (
    output alu_wbck_i_valid, alu_wbck_i_data, alu_wbck_i_rdidx,
    output qc_wbck_i_valid, qc_wbck_i_data, qc_wbck_i_rdidx,
    output longp_wbck_i_valid, longp_wbck_i_data, longp_wbck_i_rdidx,
    input  alu_wbck_i_ready, qc_wbck_i_ready, longp_wbck_i_ready,
    input  rf_wbck_ena, rf_wbck_rdidx, rf_wbck_wdat, rf_wbck_src, longp_ret_o
  );

  modport slave (
    input  alu_wbck_i_valid, alu_wbck_i_data, alu_wbck_i_rdidx,
    input  qc_wbck_i_valid, qc_wbck_i_data, qc_wbck_i_rdidx,
    input  longp_wbck_i_valid, longp_wbck_i_data, longp_wbck_i_rdidx,
    output alu_wbck_i_ready, qc_wbck_i_ready, longp_wbck_i_ready,
    output rf_wbck_ena, rf_wbck_rdidx, rf_wbck_wdat, rf_wbck_src, longp_ret_o
  );
endinterface

// File: rtl/qpu_exu_cwbck_arbt.sv
// CRF write-port arbiter (ALU / qc / longp) with anti-starvation; QPU_CWBCK_ARBT_RR_EN selects round-robin base priority.
// Latency: 1 cycle from valid&ready to the registered CRF write and OITF retire pulse.
// Backpressure: ready is the combinational grant; the CRF never stalls, so one write per cycle.
module qpu_exu_cwbck_arbt #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst_n,
  qpu_exu_cwbck_arbt_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Requester index: 0 = ALU, 1 = qc, 2 = longp (matches rf_wbck_src encoding)
  logic [2:0]         req_vld;
  logic [3:0]         starve_cnt [3];
  logic [2:0]         starved;
  logic [2:0]         cand;
  logic [2:0]         grant;
  logic               xfer;
  logic [1:0]         win_src;
  logic [XLEN-1:0]    win_data;
  logic [RFIDX_W-1:0] win_idx;

  logic               wb_ena_q;
  logic [RFIDX_W-1:0] wb_idx_q;
  logic [XLEN-1:0]    wb_dat_q;
  logic [1:0]         wb_src_q;
  logic               ret_q;

  assign req_vld = {bus.longp_wbck_i_valid, bus.qc_wbck_i_valid, bus.alu_wbck_i_valid};

  function automatic logic [2:0] pick3(input logic [2:0] c, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] d);
    logic [2:0] r;
    r = '0;
    if (c[a])      r[a] = 1'b1;
    else if (c[b]) r[b] = 1'b1;
    else if (c[d]) r[d] = 1'b1;
    return r;
  endfunction

`ifdef QPU_CWBCK_ARBT_RR_EN
  logic [1:0] last_ptr;
`endif

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      starved[i] = req_vld[i] && (starve_cnt[i] == STARVE_LIM);
    end
    // Starved requesters shadow everyone else; the base order then picks among them
    cand = (|starved) ? starved : req_vld;
`ifdef QPU_CWBCK_ARBT_RR_EN
    unique case (last_ptr)
      2'd1:    grant = pick3(cand, 2'd0, 2'd2, 2'd1);
      2'd2:    grant = pick3(cand, 2'd1, 2'd0, 2'd2);
      default: grant = pick3(cand, 2'd2, 2'd1, 2'd0);
    endcase
`else
    grant = pick3(cand, 2'd2, 2'd1, 2'd0);
`endif
    if (!rst_n) grant = '0;
  end

  assign xfer = |grant;

  always_comb begin
    win_src  = 2'd0;
    win_data = bus.alu_wbck_i_data;
    win_idx  = bus.alu_wbck_i_rdidx;
    if (grant[2]) begin
      win_src  = 2'd2;
      win_data = bus.longp_wbck_i_data;
      win_idx  = bus.longp_wbck_i_rdidx;
    end else if (grant[1]) begin
      win_src  = 2'd1;
      win_data = bus.qc_wbck_i_data;
      win_idx  = bus.qc_wbck_i_rdidx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_ena_q <= 1'b0;
      wb_idx_q <= '0;
      wb_dat_q <= '0;
      wb_src_q <= 2'd0;
      ret_q    <= 1'b0;
      for (int i = 0; i < 3; i++) starve_cnt[i] <= 4'd0;
    end else begin
      // x0 writes consume the grant but never reach the register file
      wb_ena_q <= xfer && (win_idx != '0);
      ret_q    <= grant[2];
      if (xfer) begin
        wb_idx_q <= win_idx;
        wb_dat_q <= win_data;
        wb_src_q <= win_src;
      end
      for (int i = 0; i < 3; i++) begin
        if (!req_vld[i] || grant[i])        starve_cnt[i] <= 4'd0;
        else if (starve_cnt[i] != STARVE_LIM) starve_cnt[i] <= starve_cnt[i] + 4'd1;
      end
    end
  end

`ifdef QPU_CWBCK_ARBT_RR_EN
  // Pointer starts at ALU so longp leads the first rotation after reset
  always_ff @(posedge clk) begin
    if (!rst_n)    last_ptr <= 2'd0;
    else if (xfer) last_ptr <= win_src;
  end
`endif

  assign bus.alu_wbck_i_ready   = grant[0];
  assign bus.qc_wbck_i_ready    = grant[1];
  assign bus.longp_wbck_i_ready = grant[2];
  assign bus.rf_wbck_ena        = wb_ena_q;
  assign bus.rf_wbck_rdidx      = wb_idx_q;
  assign bus.rf_wbck_wdat       = wb_dat_q;
  assign bus.rf_wbck_src        = wb_src_q;
  assign bus.longp_ret_o        = ret_q;

endmodule
